timer_ctrl: RTL

- Mode controller and countdown sequencer for the Basys3 MM:SS timer.
- Consumes single-cycle tick strobes produced upstream from the clock divider, plus debounced buttons.
- Owns the set/run/pause/alarm state machine and the BCD time registers.
- Drives digit values, blink mask and alarm to the display and LED stage.

---
 rtl/timer_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/timer_ctrl.sv
// MM:SS countdown timer controller: set/run/pause/alarm FSM driving BCD digits.
// Optional ALARM auto-clear after ALARM_SECS seconds: define TIMER_CTRL_ALARM_TIMEOUT_EN.
module timer_ctrl #(
  parameter int MAX_MIN    = 99,
  parameter int ALARM_SECS = 10
) (
  input  logic       clk_sourecs,
  input  logic       rest,
  input  logic       tick_1hz,
  input  logic       tick_long,
  input  logic       btn_start,
  input  logic       btn_set,
  input  logic       btn_up,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] blink_mask,
  output logic       running,
  output logic       alarm
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SET_MIN = 3'd1,
    SET_SEC = 3'd2,
    RUN     = 3'd3,
    PAUSE   = 3'd4,
    ALARM   = 3'd5
  } state_t;

  localparam logic [3:0] MAX_T = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_O = 4'(MAX_MIN % 10);

  state_t     state_reg, state_next;
  logic [3:0] mt_reg, mo_reg, st_reg, so_reg;
  logic [3:0] mt_next, mo_next, st_next, so_next;
  logic       start_prev_reg, set_prev_reg, up_prev_reg;
  logic [1:0] hold_reg, hold_next;

  logic start_edge, set_edge, up_edge, up_step;
  logic [3:0] inc_mt, inc_mo, inc_st, inc_so;
  logic [3:0] dec_mt, dec_mo, dec_st, dec_so;

  assign start_edge = btn_start & ~start_prev_reg;
  assign set_edge   = btn_set & ~set_prev_reg;
  assign up_edge    = btn_up & ~up_prev_reg;
  // Auto-repeat kicks in only after two tick_long strobes of continuous hold.
  assign up_step    = up_edge | (btn_up & tick_long & (hold_reg == 2'd2));

  always_comb begin
    hold_next = hold_reg;
    if (!btn_up)
      hold_next = 2'd0;
    else if (tick_long && hold_reg != 2'd2)
      hold_next = hold_reg + 2'd1;
  end

  // BCD increment with wrap for minutes (MAX_MIN -> 00) and seconds (59 -> 00)
  always_comb begin
    inc_mt = mt_reg;
    inc_mo = mo_reg + 4'd1;
    if (mt_reg == MAX_T && mo_reg == MAX_O) begin
      inc_mt = 4'd0;
      inc_mo = 4'd0;
    end else if (mo_reg == 4'd9) begin
      inc_mt = mt_reg + 4'd1;
      inc_mo = 4'd0;
    end
    inc_st = st_reg;
    inc_so = so_reg + 4'd1;
    if (st_reg == 4'd5 && so_reg == 4'd9) begin
      inc_st = 4'd0;
      inc_so = 4'd0;
    end else if (so_reg == 4'd9) begin
      inc_st = st_reg + 4'd1;
      inc_so = 4'd0;
    end
  end

  // One-second BCD decrement; only used while time is nonzero
  always_comb begin
    dec_mt = mt_reg;
    dec_mo = mo_reg;
    dec_st = st_reg;
    dec_so = so_reg - 4'd1;
    if (so_reg == 4'd0) begin
      dec_so = 4'd9;
      dec_st = st_reg - 4'd1;
      if (st_reg == 4'd0) begin
        dec_st = 4'd5;
        dec_mo = mo_reg - 4'd1;
        if (mo_reg == 4'd0) begin
          dec_mo = 4'd9;
          dec_mt = mt_reg - 4'd1;
        end
      end
    end
  end

`ifdef TIMER_CTRL_ALARM_TIMEOUT_EN
  localparam int ACW = $clog2(ALARM_SECS + 1);
  logic [ACW-1:0] acnt_reg;
  logic           alarm_expire;

  assign alarm_expire = tick_1hz && (acnt_reg == ACW'(ALARM_SECS - 1));

  always_ff @(posedge clk_sourecs) begin
    if (rest || state_reg != ALARM)
      acnt_reg <= '0;
    else if (tick_1hz)
      acnt_reg <= acnt_reg + ACW'(1);
  end
`else
  logic alarm_expire;
  assign alarm_expire = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    mt_next    = mt_reg;
    mo_next    = mo_reg;
    st_next    = st_reg;
    so_next    = so_reg;
    case (state_reg)
      IDLE: begin
        if (set_edge)
          state_next = SET_MIN;
        else if (start_edge && {mt_reg, mo_reg, st_reg, so_reg} != 16'h0000)
          state_next = RUN;
      end
      SET_MIN: begin
        if (up_step) begin
          mt_next = inc_mt;
          mo_next = inc_mo;
        end
        if (set_edge)
          state_next = SET_SEC;
      end
      SET_SEC: begin
        if (up_step) begin
          st_next = inc_st;
          so_next = inc_so;
        end
        if (set_edge)
          state_next = IDLE;
      end
      RUN: begin
        if (start_edge) begin
          state_next = PAUSE;
        end else if (tick_1hz) begin
          mt_next = dec_mt;
          mo_next = dec_mo;
          st_next = dec_st;
          so_next = dec_so;
          if ({dec_mt, dec_mo, dec_st, dec_so} == 16'h0000)
            state_next = ALARM;
        end
      end
      PAUSE: begin
        if (start_edge)
          state_next = RUN;
        else if (set_edge)
          state_next = IDLE;
      end
      ALARM: begin
        mt_next = 4'd0;
        mo_next = 4'd0;
        st_next = 4'd0;
        so_next = 4'd0;
        if (start_edge || set_edge || alarm_expire)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_sourecs) begin
    if (rest) begin
      state_reg      <= IDLE;
      mt_reg         <= 4'd0;
      mo_reg         <= 4'd0;
      st_reg         <= 4'd0;
      so_reg         <= 4'd0;
      start_prev_reg <= 1'b0;
      set_prev_reg   <= 1'b0;
      up_prev_reg    <= 1'b0;
      hold_reg       <= 2'd0;
    end else begin
      state_reg      <= state_next;
      mt_reg         <= mt_next;
      mo_reg         <= mo_next;
      st_reg         <= st_next;
      so_reg         <= so_next;
      start_prev_reg <= btn_start;
      set_prev_reg   <= btn_set;
      up_prev_reg    <= btn_up;
      hold_reg       <= hold_next;
    end
  end

  assign min_tens = mt_reg;
  assign min_ones = mo_reg;
  assign sec_tens = st_reg;
  assign sec_ones = so_reg;
  assign running  = (state_reg == RUN);
  assign alarm    = (state_reg == ALARM);

  always_comb begin
    case (state_reg)
      SET_MIN: blink_mask = 4'b1100;
      SET_SEC: blink_mask = 4'b0011;
      PAUSE:   blink_mask = 4'b1111;
      default: blink_mask = 4'b0000;
    endcase
  end

endmodule
